// File: rtl/sdram_slot_arbiter.sv
// Two-port SDRAM slot arbiter. Port A (CPU) and port B (video) share fixed-length
// slots marked by sync, with round-robin fairness and a forced refresh slot after REFRESH_GAP grants.
module sdram_slot_arbiter #(
    parameter int REFRESH_GAP = 7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sync,
    input  logic        a_req,
    input  logic        a_we,
    input  logic [1:0]  a_ds,
    input  logic [19:0] a_addr,
    input  logic [15:0] a_din,
    output logic        a_ack,
    output logic [15:0] a_dout,
    input  logic        b_req,
    input  logic [19:0] b_addr,
    output logic        b_ack,
    output logic [15:0] b_dout,
    output logic        we,
    output logic        oe,
    output logic [1:0]  ds,
    output logic [19:0] addr,
    output logic [15:0] din,
    input  logic [15:0] dout
);

    localparam int CNT_W = (REFRESH_GAP < 1) ? 1 : $clog2(REFRESH_GAP + 1);
    localparam logic [CNT_W-1:0] GAP     = CNT_W'(REFRESH_GAP);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SLOT_A = 2'd1,
        SLOT_B = 2'd2
    } slot_t;

    slot_t            state;
    logic [CNT_W-1:0] gnt_cnt;
    logic             rr_favor_a;

    logic a_elig;
    logic b_elig;
    logic refresh_due;
    logic grant_a;
    logic grant_b;

    // The port whose slot is finishing at this sync is not eligible for the next one.
    assign a_elig      = a_req && (state != SLOT_A);
    assign b_elig      = b_req && (state != SLOT_B);
    assign refresh_due = (gnt_cnt == GAP);
    assign grant_a     = !refresh_due && a_elig && (!b_elig || rr_favor_a);
    assign grant_b     = !refresh_due && b_elig && !grant_a;

    // NOTE: every register here uses <= so all updates see pre-edge values of state and counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            gnt_cnt    <= '0;
            rr_favor_a <= 1'b1;
            we         <= 1'b0;
            oe         <= 1'b0;
            ds         <= 2'b00;
            addr       <= '0;
            din        <= '0;
            a_ack      <= 1'b0;
            b_ack      <= 1'b0;
            a_dout     <= '0;
            b_dout     <= '0;
        end else begin
            a_ack <= 1'b0;
            b_ack <= 1'b0;
            if (sync) begin
                case (state)
                    SLOT_A: begin
                        a_ack <= 1'b1;
                        if (oe) a_dout <= dout;
                    end
                    SLOT_B: begin
                        b_ack  <= 1'b1;
                        b_dout <= dout;
                    end
                    default: ;
                endcase

                if (grant_a) begin
                    state      <= SLOT_A;
                    we         <= a_we;
                    oe         <= ~a_we;
                    ds         <= a_ds;
                    addr       <= a_addr;
                    din        <= a_din;
                    gnt_cnt    <= gnt_cnt + CNT_ONE;
                    rr_favor_a <= 1'b0;
                end else if (grant_b) begin
                    state      <= SLOT_B;
                    we         <= 1'b0;
                    oe         <= 1'b1;
                    ds         <= 2'b11;
                    addr       <= b_addr;
                    din        <= '0;
                    gnt_cnt    <= gnt_cnt + CNT_ONE;
                    rr_favor_a <= 1'b1;
                end else begin
                    // Idle slot: the SDRAM controller refreshes; addr/din keep their last values.
                    state   <= IDLE;
                    we      <= 1'b0;
                    oe      <= 1'b0;
                    ds      <= 2'b00;
                    gnt_cnt <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_sdram_slot_arbiter.sv
// Scoreboard bench for sdram_slot_arbiter: a slot-level reference model predicts each
// sync's outcome into a queue, and a monitor compares the DUT outputs on every cycle.
module tb_sdram_slot_arbiter;

    localparam int GAP = 7;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sync = 1'b0;
    logic        a_req = 1'b0, a_we = 1'b0;
    logic [1:0]  a_ds = 2'b00;
    logic [19:0] a_addr = '0, b_addr = '0;
    logic [15:0] a_din = '0, dout = '0;
    logic        b_req = 1'b0;
    logic        a_ack, b_ack, we, oe;
    logic [15:0] a_dout, b_dout, din;
    logic [1:0]  ds;
    logic [19:0] addr;

    int checks = 0;
    int errors = 0;

    sdram_slot_arbiter #(.REFRESH_GAP(GAP)) dut (
        .clk(clk), .reset(reset), .sync(sync),
        .a_req(a_req), .a_we(a_we), .a_ds(a_ds), .a_addr(a_addr), .a_din(a_din),
        .a_ack(a_ack), .a_dout(a_dout),
        .b_req(b_req), .b_addr(b_addr), .b_ack(b_ack), .b_dout(b_dout),
        .we(we), .oe(oe), .ds(ds), .addr(addr), .din(din), .dout(dout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we, oe;
        logic [1:0]  ds;
        logic [19:0] addr;
        logic [15:0] din;
        logic        a_ack, b_ack;
        logic [15:0] a_dout, b_dout;
    } exp_t;

    exp_t exp_q[$];

    // Slot-level model: owner 0=none, 1=A, 2=B; last_port is the last granted port.
    int          m_owner, m_cnt, m_last_port;
    logic        m_a_read;
    exp_t        m_out;

    function automatic exp_t zero_exp();
        exp_t e;
        e.we = 0; e.oe = 0; e.ds = 0; e.addr = 0; e.din = 0;
        e.a_ack = 0; e.b_ack = 0; e.a_dout = 0; e.b_dout = 0;
        return e;
    endfunction

    task automatic model_reset();
        m_owner = 0; m_cnt = 0; m_last_port = 0; m_a_read = 0;
        m_out = zero_exp();
    endtask

    task automatic model_sync();
        bit a_ok, b_ok;
        int pick;
        m_out.a_ack = (m_owner == 1);
        m_out.b_ack = (m_owner == 2);
        if (m_owner == 1 && m_a_read) m_out.a_dout = dout;
        if (m_owner == 2) m_out.b_dout = dout;
        a_ok = a_req && m_owner != 1;
        b_ok = b_req && m_owner != 2;
        pick = 0;
        if (m_cnt < GAP) begin
            if (a_ok && b_ok) pick = (m_last_port == 1) ? 2 : 1;
            else if (a_ok)   pick = 1;
            else if (b_ok)   pick = 2;
        end
        case (pick)
            1: begin
                m_out.we = a_we; m_out.oe = !a_we; m_out.ds = a_ds;
                m_out.addr = a_addr; m_out.din = a_din; m_a_read = !a_we;
            end
            2: begin
                m_out.we = 0; m_out.oe = 1; m_out.ds = 2'b11;
                m_out.addr = b_addr; m_out.din = 0;
            end
            default: begin
                m_out.we = 0; m_out.oe = 0; m_out.ds = 2'b00;
            end
        endcase
        m_cnt   = (pick != 0) ? m_cnt + 1 : 0;
        m_owner = pick;
        if (pick != 0) m_last_port = pick;
        exp_q.push_back(m_out);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic compare(input exp_t e);
        check("we", 32'(we), 32'(e.we));
        check("oe", 32'(oe), 32'(e.oe));
        check("ds", 32'(ds), 32'(e.ds));
        check("addr", 32'(addr), 32'(e.addr));
        check("din", 32'(din), 32'(e.din));
        check("a_ack", 32'(a_ack), 32'(e.a_ack));
        check("b_ack", 32'(b_ack), 32'(e.b_ack));
        check("a_dout", 32'(a_dout), 32'(e.a_dout));
        check("b_dout", 32'(b_dout), 32'(e.b_dout));
    endtask

    // Monitor: a sync at the last posedge means a new expected outcome is presented.
    logic sync_q = 1'b0;
    exp_t cur;
    always @(posedge clk) sync_q <= sync;

    always @(negedge clk) begin
        if (reset) begin
            cur = zero_exp();
            compare(cur);
        end else if (sync_q) begin
            if (exp_q.size() == 0) begin
                check("queue_underflow", 32'd1, 32'd0);
            end else begin
                cur = exp_q.pop_front();
                compare(cur);
                cur.a_ack = 0;
                cur.b_ack = 0;
            end
        end else begin
            compare(cur);
        end
    end

    task automatic scramble();
        a_req = 1'($urandom); a_we = 1'($urandom); a_ds = 2'($urandom);
        a_addr = 20'($urandom); a_din = 16'($urandom);
        b_req = 1'($urandom); b_addr = 20'($urandom); dout = 16'($urandom);
    endtask

    task automatic do_slot(input logic ar, input logic aw, input logic [1:0] ads,
                           input logic [19:0] aa, input logic [15:0] ad,
                           input logic br, input logic [19:0] ba,
                           input logic [15:0] dv, input int len);
        @(negedge clk);
        a_req = ar; a_we = aw; a_ds = ads; a_addr = aa; a_din = ad;
        b_req = br; b_addr = ba; dout = dv; sync = 1'b1;
        model_sync();
        for (int i = 1; i < len; i++) begin
            @(negedge clk);
            sync = 1'b0;
            scramble();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Single A write, then its completion
        do_slot(1, 1, 2'b11, 20'h12345, 16'hBEEF, 0, 20'h0, 16'h0, 3);
        do_slot(0, 0, 2'b00, 20'h0, 16'h0, 0, 20'h0, 16'h0, 2);
        // Single B read with data returned at the end of the slot
        do_slot(0, 0, 2'b00, 20'h0, 16'h0, 1, 20'h00100, 16'h0, 3);
        do_slot(0, 0, 2'b00, 20'h0, 16'h0, 0, 20'h0, 16'h5A5A, 2);

        // Idle period: nothing requested
        for (int i = 0; i < 20; i++)
            do_slot(0, 0, 2'b00, 20'h0, 16'h0, 0, 20'h0, 16'($urandom), 1 + (i % 2));

        // Continuous contention: alternation with a forced idle every GAP+1 slots
        for (int i = 0; i < 24; i++)
            do_slot(1, i[0], 2'b11, 20'(i), 16'(i * 3), 1, 20'(i + 100), 16'($urandom), 2);

        // Port A held high alone through its acks
        for (int i = 0; i < 8; i++)
            do_slot(1, 0, 2'b01, 20'(i + 500), 16'h0, 0, 20'h0, 16'($urandom), 1 + (i % 3));

        // Randomized traffic, including back-to-back syncs and mid-slot input churn
        for (int i = 0; i < 300; i++)
            do_slot(1'($urandom_range(0, 9) < 7), 1'($urandom), 2'($urandom),
                    20'($urandom), 16'($urandom), 1'($urandom_range(0, 9) < 6),
                    20'($urandom), 16'($urandom), $urandom_range(1, 3));

        // Reset in the middle of an A read slot
        do_slot(0, 0, 2'b00, 20'h0, 16'h0, 0, 20'h0, 16'h0, 2);
        do_slot(1, 0, 2'b11, 20'h0ABCD, 16'h0, 0, 20'h0, 16'h0, 3);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("rst_a_ack", 32'(a_ack), 32'd0);
        check("rst_oe", 32'(oe), 32'd0);
        check("rst_addr", 32'(addr), 32'd0);
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        do_slot(1, 1, 2'b10, 20'h0F0F0, 16'h1234, 0, 20'h0, 16'h7777, 2);
        do_slot(0, 0, 2'b00, 20'h0, 16'h0, 1, 20'h00042, 16'h8888, 2);
        do_slot(0, 0, 2'b00, 20'h0, 16'h0, 0, 20'h0, 16'h9999, 2);

        @(negedge clk);
        sync = 1'b0;
        repeat (4) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
